// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Hazard-detection inputs and the stage-register controls exchanged between the
// pipeline datapath and the central stall/flush sequencer.
//   master : pipeline side; drives the decoded hazard information and receives
//            the PC/IF-ID write enables, IF flush, ID/EX bubble and pipe hold.
//   slave  : the sequencer (pipeline_hazard_ctrl).
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       ID_UsesRt;
    logic       ID_Jump;
    logic       EX_MemRead;
    logic [4:0] EX_Rt;
    logic       EX_BranchTaken;
    logic       mem_busy;

    logic       PC_Write;
    logic       IF_ID_Write;
    logic       IF_Flush;
    logic       ID_EX_Bubble;
    logic       pipe_hold;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_Jump,
        output EX_MemRead, EX_Rt, EX_BranchTaken, mem_busy,
        input  PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, pipe_hold
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_Jump,
        input  EX_MemRead, EX_Rt, EX_BranchTaken, mem_busy,
        output PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, pipe_hold
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Resolves load-use
// hazards, taken branches, jumps and data-memory waits under one fixed
// priority (hold > branch > load-use > jump > none). A watchdog halts the
// pipeline permanently if memory stays busy for MEM_TIMEOUT cycles.
//
// Ports:
//   sysclk      clock, rising edge
//   reset       asynchronous, active-low
//   hz          hazard inputs / stage-register controls (slave modport)
//   mem_timeout sticky watchdog error flag
//   ctrl_state  0=RUN, 1=MEM_WAIT, 2=HALT
//   stall_cnt   saturating count of cycles with PC_Write=0
//   flush_cnt   saturating count of cycles with IF_Flush=1
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   sysclk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz,
    output logic                   mem_timeout,
    output logic [1:0]             ctrl_state,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    state_e            state, stateNext;
    logic [WAIT_W-1:0] waitCnt, waitCntNext;
    logic              timeoutNext;
    logic              loadUse;
    logic              holdCond;

    // ---------------- state register ----------------
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            waitCnt     <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= stateNext;
            waitCnt     <= waitCntNext;
            mem_timeout <= timeoutNext;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        timeoutNext = mem_timeout;
        case (state)
            RUN: begin
                if (hz.mem_busy) begin
                    stateNext   = MEM_WAIT;
                    waitCntNext = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!hz.mem_busy) begin
                    stateNext   = RUN;
                    waitCntNext = '0;
                end else if (waitCnt == WAIT_LAST) begin
                    stateNext   = HALT;
                    timeoutNext = 1'b1;
                end else begin
                    waitCntNext = waitCnt + WAIT_W'(1);
                end
            end
            // HALT and the unused code 3 are both terminal until reset.
            default: ;
        endcase
    end

    // ---------------- output logic (Mealy) ----------------
    always_comb begin
        loadUse = hz.EX_MemRead && (hz.EX_Rt != 5'd0) &&
                  ((hz.EX_Rt == hz.ID_Rs) || (hz.ID_UsesRt && (hz.EX_Rt == hz.ID_Rt)));
        // Busy only holds while the FSM is still tracking memory; HALT ignores it.
        holdCond = ((state != RUN) && (state != MEM_WAIT)) || hz.mem_busy;

        hz.PC_Write     = 1'b1;
        hz.IF_ID_Write  = 1'b1;
        hz.IF_Flush     = 1'b0;
        hz.ID_EX_Bubble = 1'b0;
        hz.pipe_hold    = 1'b0;

        if (!reset) begin
            hz.PC_Write     = 1'b0;
            hz.IF_ID_Write  = 1'b0;
            hz.IF_Flush     = 1'b1;
            hz.ID_EX_Bubble = 1'b1;
        end else if (holdCond) begin
            // A taken branch is simply left in EX and serviced on release.
            hz.PC_Write    = 1'b0;
            hz.IF_ID_Write = 1'b0;
            hz.pipe_hold   = 1'b1;
        end else if (hz.EX_BranchTaken) begin
            // Branch beats load-use: the dependent instruction is being killed.
            hz.IF_Flush     = 1'b1;
            hz.ID_EX_Bubble = 1'b1;
        end else if (loadUse) begin
            // Jump+load-use stalls without flushing; the jump re-asserts next cycle.
            hz.PC_Write     = 1'b0;
            hz.IF_ID_Write  = 1'b0;
            hz.ID_EX_Bubble = 1'b1;
        end else if (hz.ID_Jump) begin
            hz.IF_Flush = 1'b1;
        end
    end

    assign ctrl_state = state;

    // ---------------- saturating performance counters ----------------
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!hz.PC_Write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (hz.IF_Flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    always #5 sysclk = ~sysclk;

    pipeline_hazard_ctrl_if ifA ();
    pipeline_hazard_ctrl_if ifB ();

    logic        toA, toB;
    logic [1:0]  stA, stB;
    logic [15:0] scA, fcA;
    logic [3:0]  scB, fcB;

    pipeline_hazard_ctrl dutA (
        .sysclk      (sysclk),
        .reset       (reset),
        .hz          (ifA),
        .mem_timeout (toA),
        .ctrl_state  (stA),
        .stall_cnt   (scA),
        .flush_cnt   (fcA)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dutB (
        .sysclk      (sysclk),
        .reset       (reset),
        .hz          (ifB),
        .mem_timeout (toB),
        .ctrl_state  (stB),
        .stall_cnt   (scB),
        .flush_cnt   (fcB)
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic       usesRt, jump, memRead;
        logic [4:0] exRt;
        logic       br, busy;
    } stim_t;

    typedef struct {
        logic pc, ifid, flush, bub, hold;
    } ctl_t;

    typedef struct {
        stim_t s;
        ctl_t  e;
    } vec_t;

    // Abstract model: tracks the length of the current busy run, not a wait counter.
    typedef struct {
        bit halted;
        bit tout;
        int busyRun;
        int stalls;
        int flushes;
        int limit;
        int cntMax;
    } model_t;

    model_t mA, mB;
    stim_t  cur;
    ctl_t   eA, eB;
    int     nVec = 0;
    int     nMis = 0;

    function automatic stim_t mk(int rs, int rt, int usesRt, int jump,
                                 int memRead, int exRt, int br, int busy);
        stim_t s;
        s.rs = 5'(rs); s.rt = 5'(rt); s.usesRt = 1'(usesRt); s.jump = 1'(jump);
        s.memRead = 1'(memRead); s.exRt = 5'(exRt); s.br = 1'(br); s.busy = 1'(busy);
        return s;
    endfunction

    function automatic ctl_t mc(int pc, int ifid, int flush, int bub, int hold);
        ctl_t c;
        c.pc = 1'(pc); c.ifid = 1'(ifid); c.flush = 1'(flush); c.bub = 1'(bub); c.hold = 1'(hold);
        return c;
    endfunction

    function automatic model_t freshModel(int limit, int cntW);
        model_t m;
        m.halted = 0; m.tout = 0; m.busyRun = 0; m.stalls = 0; m.flushes = 0;
        m.limit = limit; m.cntMax = (1 << cntW) - 1;
        return m;
    endfunction

    function automatic ctl_t predict(model_t m, stim_t s);
        bit lu;
        lu = s.memRead && (s.exRt != 0) &&
             ((s.exRt == s.rs) || (s.usesRt && (s.exRt == s.rt)));
        if (m.halted || s.busy) return mc(0, 0, 0, 0, 1);
        if (s.br)               return mc(1, 1, 1, 1, 0);
        if (lu)                 return mc(0, 0, 0, 1, 0);
        if (s.jump)             return mc(1, 1, 1, 0, 0);
        return mc(1, 1, 0, 0, 0);
    endfunction

    function automatic model_t advance(model_t m, ctl_t c, stim_t s);
        if (!m.halted) begin
            if (s.busy) begin
                m.busyRun++;
                if (m.busyRun >= m.limit) begin
                    m.halted = 1;
                    m.tout   = 1;
                end
            end else begin
                m.busyRun = 0;
            end
        end
        if (!c.pc && m.stalls < m.cntMax)     m.stalls++;
        if (c.flush && m.flushes < m.cntMax)  m.flushes++;
        return m;
    endfunction

    function automatic int stateOf(model_t m);
        if (m.halted)      return 2;
        if (m.busyRun > 0) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOne(input string tag, input ctl_t e, input int st, input int to,
                            input int sc, input int fc,
                            input logic pc, input logic ifid, input logic flush,
                            input logic bub, input logic hold, input logic [1:0] ast,
                            input logic ato, input int asc, input int afc);
        chk({tag, ".PC_Write"},     32'(pc),    32'(e.pc));
        chk({tag, ".IF_ID_Write"},  32'(ifid),  32'(e.ifid));
        chk({tag, ".IF_Flush"},     32'(flush), 32'(e.flush));
        chk({tag, ".ID_EX_Bubble"}, 32'(bub),   32'(e.bub));
        chk({tag, ".pipe_hold"},    32'(hold),  32'(e.hold));
        chk({tag, ".ctrl_state"},   32'(ast),   32'(st));
        chk({tag, ".mem_timeout"},  32'(ato),   32'(to));
        chk({tag, ".stall_cnt"},    32'(asc),   32'(sc));
        chk({tag, ".flush_cnt"},    32'(afc),   32'(fc));
    endtask

    task automatic setInputs(input stim_t s);
        ifA.ID_Rs = s.rs; ifA.ID_Rt = s.rt; ifA.ID_UsesRt = s.usesRt; ifA.ID_Jump = s.jump;
        ifA.EX_MemRead = s.memRead; ifA.EX_Rt = s.exRt; ifA.EX_BranchTaken = s.br; ifA.mem_busy = s.busy;
        ifB.ID_Rs = s.rs; ifB.ID_Rt = s.rt; ifB.ID_UsesRt = s.usesRt; ifB.ID_Jump = s.jump;
        ifB.EX_MemRead = s.memRead; ifB.EX_Rt = s.exRt; ifB.EX_BranchTaken = s.br; ifB.mem_busy = s.busy;
    endtask

    // Apply one cycle's inputs and compare both DUTs against the model.
    task automatic drive(input stim_t s);
        cur = s;
        setInputs(s);
        #1;
        eA = predict(mA, s);
        eB = predict(mB, s);
        checkOne("A", eA, stateOf(mA), int'(mA.tout), mA.stalls, mA.flushes,
                 ifA.PC_Write, ifA.IF_ID_Write, ifA.IF_Flush, ifA.ID_EX_Bubble, ifA.pipe_hold,
                 stA, toA, int'(scA), int'(fcA));
        checkOne("B", eB, stateOf(mB), int'(mB.tout), mB.stalls, mB.flushes,
                 ifB.PC_Write, ifB.IF_ID_Write, ifB.IF_Flush, ifB.ID_EX_Bubble, ifB.pipe_hold,
                 stB, toB, int'(scB), int'(fcB));
    endtask

    task automatic tick();
        mA = advance(mA, eA, cur);
        mB = advance(mB, eB, cur);
        @(posedge sysclk);
        #1;
    endtask

    task automatic doReset();
        ctl_t r;
        r = mc(0, 0, 1, 1, 0);
        reset = 1'b0;
        #1;
        checkOne("rstA", r, 0, 0, 0, 0,
                 ifA.PC_Write, ifA.IF_ID_Write, ifA.IF_Flush, ifA.ID_EX_Bubble, ifA.pipe_hold,
                 stA, toA, int'(scA), int'(fcA));
        checkOne("rstB", r, 0, 0, 0, 0,
                 ifB.PC_Write, ifB.IF_ID_Write, ifB.IF_Flush, ifB.ID_EX_Bubble, ifB.pipe_hold,
                 stB, toB, int'(scB), int'(fcB));
        reset = 1'b1;
        mA = freshModel(16, 16);
        mB = freshModel(4, 4);
        #1;
    endtask

    vec_t  tbl[14];
    stim_t none, luS, brLu, jmpLu, busyBr;

    initial begin
        // Hand-computed vectors starting from RUN (DUT A expectations).
        tbl[0]  = '{mk(1, 2, 1, 0, 0, 0, 0, 0), mc(1, 1, 0, 0, 0)};  // idle
        tbl[1]  = '{mk(8, 3, 0, 0, 1, 8, 0, 0), mc(0, 0, 0, 1, 0)};  // lu via Rs
        tbl[2]  = '{mk(4, 9, 1, 0, 1, 9, 0, 0), mc(0, 0, 0, 1, 0)};  // lu via Rt
        tbl[3]  = '{mk(4, 9, 0, 0, 1, 9, 0, 0), mc(1, 1, 0, 0, 0)};  // Rt unused
        tbl[4]  = '{mk(0, 0, 1, 0, 1, 0, 0, 0), mc(1, 1, 0, 0, 0)};  // r0 never hazards
        tbl[5]  = '{mk(8, 8, 1, 0, 0, 8, 0, 0), mc(1, 1, 0, 0, 0)};  // not a load
        tbl[6]  = '{mk(1, 2, 0, 1, 0, 0, 0, 0), mc(1, 1, 1, 0, 0)};  // jump
        tbl[7]  = '{mk(1, 2, 0, 0, 0, 0, 1, 0), mc(1, 1, 1, 1, 0)};  // branch
        tbl[8]  = '{mk(5, 0, 0, 0, 1, 5, 1, 0), mc(1, 1, 1, 1, 0)};  // branch + lu
        tbl[9]  = '{mk(5, 0, 0, 1, 1, 5, 0, 0), mc(0, 0, 0, 1, 0)};  // jump + lu
        tbl[10] = '{mk(1, 2, 0, 0, 0, 0, 1, 1), mc(0, 0, 0, 0, 1)};  // busy + branch
        tbl[11] = '{mk(1, 2, 0, 0, 0, 0, 1, 0), mc(1, 1, 1, 1, 0)};  // release w/ branch
        tbl[12] = '{mk(5, 0, 0, 1, 1, 5, 0, 1), mc(0, 0, 0, 0, 1)};  // busy + jump + lu
        tbl[13] = '{mk(1, 2, 0, 1, 0, 0, 0, 0), mc(1, 1, 1, 0, 0)};  // release w/ jump

        none   = mk(1, 2, 0, 0, 0, 0, 0, 0);
        luS    = mk(8, 0, 0, 0, 1, 8, 0, 0);
        brLu   = mk(5, 0, 0, 0, 1, 5, 1, 0);
        jmpLu  = mk(5, 0, 0, 1, 1, 5, 0, 0);
        busyBr = mk(1, 2, 0, 0, 0, 0, 1, 1);

        mA = freshModel(16, 16);
        mB = freshModel(4, 4);
        setInputs(none);
        @(posedge sysclk);
        #1;
        doReset();

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].s);
            chk($sformatf("tbl%0d.PC_Write", i),     32'(ifA.PC_Write),     32'(tbl[i].e.pc));
            chk($sformatf("tbl%0d.IF_ID_Write", i),  32'(ifA.IF_ID_Write),  32'(tbl[i].e.ifid));
            chk($sformatf("tbl%0d.IF_Flush", i),     32'(ifA.IF_Flush),     32'(tbl[i].e.flush));
            chk($sformatf("tbl%0d.ID_EX_Bubble", i), 32'(ifA.ID_EX_Bubble), 32'(tbl[i].e.bub));
            chk($sformatf("tbl%0d.pipe_hold", i),    32'(ifA.pipe_hold),    32'(tbl[i].e.hold));
            tick();
        end

        // Load-use: one-cycle stall, then r0 destination never stalls.
        doReset();
        drive(luS);
        chk("lu.PC_Write", 32'(ifA.PC_Write), 0);
        chk("lu.ID_EX_Bubble", 32'(ifA.ID_EX_Bubble), 1);
        tick();
        drive(none);
        chk("lu.release", 32'(ifA.PC_Write), 1);
        chk("lu.stall_cnt", 32'(scA), 1);
        tick();
        drive(mk(0, 0, 0, 0, 1, 0, 0, 0));
        chk("lu.r0", 32'(ifA.PC_Write), 1);
        tick();

        // Branch and load-use in the same cycle.
        doReset();
        drive(brLu);
        chk("brlu.IF_Flush", 32'(ifA.IF_Flush), 1);
        chk("brlu.PC_Write", 32'(ifA.PC_Write), 1);
        tick();
        drive(none);
        chk("brlu.flush_cnt", 32'(fcA), 1);
        chk("brlu.stall_cnt", 32'(scA), 0);
        tick();

        // Jump and load-use in the same cycle; jump serviced next cycle.
        doReset();
        drive(jmpLu);
        chk("jlu.IF_Flush", 32'(ifA.IF_Flush), 0);
        chk("jlu.IF_ID_Write", 32'(ifA.IF_ID_Write), 0);
        tick();
        drive(mk(5, 0, 0, 1, 0, 5, 0, 0));
        chk("jlu.retry", 32'(ifA.IF_Flush), 1);
        tick();

        // Memory wait of 5 cycles with a branch pending (B times out meanwhile).
        doReset();
        for (int i = 0; i < 5; i++) begin
            drive(busyBr);
            chk($sformatf("mw%0d.pipe_hold", i), 32'(ifA.pipe_hold), 1);
            chk($sformatf("mw%0d.IF_Flush", i), 32'(ifA.IF_Flush), 0);
            if (i > 0) chk($sformatf("mw%0d.state", i), 32'(stA), 1);
            tick();
        end
        drive(mk(1, 2, 0, 0, 0, 0, 1, 0));
        chk("mw.release_flush", 32'(ifA.IF_Flush), 1);
        chk("mw.release_hold", 32'(ifA.pipe_hold), 0);
        tick();
        drive(none);
        chk("mw.state_after", 32'(stA), 0);
        chk("mw.B_halted", 32'(stB), 2);
        tick();

        // Watchdog on B (MEM_TIMEOUT=4).
        doReset();
        for (int i = 0; i < 4; i++) begin
            drive(mk(1, 2, 0, 0, 0, 0, 0, 1));
            if (i < 3) chk($sformatf("wd%0d.timeout", i), 32'(toB), 0);
            tick();
        end
        drive(none);
        chk("wd.state", 32'(stB), 2);
        chk("wd.mem_timeout", 32'(toB), 1);
        chk("wd.hold_after", 32'(ifB.pipe_hold), 1);
        tick();
        drive(none);
        chk("wd.sticky", 32'(stB), 2);
        tick();

        // Reset while A is mid-MEM_WAIT and B is halted.
        drive(mk(1, 2, 0, 0, 0, 0, 0, 1));
        tick();
        drive(mk(1, 2, 0, 0, 0, 0, 0, 1));
        doReset();
        drive(none);
        tick();

        // Counter saturation on B (CNT_W=4).
        doReset();
        for (int i = 0; i < 20; i++) begin
            drive(luS);
            tick();
        end
        drive(none);
        chk("sat.B", 32'(scB), 15);
        chk("sat.A", 32'(scA), 20);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(luS);
            tick();
        end
        drive(none);
        chk("sat.B_hold", 32'(scB), 15);
        tick();

        // Randomized traffic against the model, with periodic resets.
        doReset();
        for (int i = 0; i < 600; i++) begin
            stim_t s;
            if (i % 75 == 74) doReset();
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.exRt    = 5'($urandom_range(0, 3));
            s.usesRt  = 1'($urandom_range(0, 1));
            s.memRead = 1'($urandom_range(0, 1));
            s.jump    = ($urandom_range(0, 4) == 0);
            s.br      = ($urandom_range(0, 4) == 0);
            s.busy    = ($urandom_range(0, 9) < 3);
            drive(s);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
